// File: rtl/dram_pkg.sv
// rtl/dram_pkg.sv - shared constants, command encoding and lane vector types for dram_model
package dram_pkg;

    localparam int N_LANES = 16;
    localparam int ADDR_W  = 64;
    localparam int DATA_W  = 8;

    typedef enum logic [1:0] {
        RDWR_NOP = 2'd0,
        RDWR_RD  = 2'd1,
        RDWR_WR  = 2'd2,
        RDWR_RSV = 2'd3
    } rdwr_e;

    typedef logic [N_LANES-1:0][DATA_W-1:0] lane_data_t;
    typedef logic [N_LANES-1:0][ADDR_W-1:0] lane_addr_t;

endpackage

// File: rtl/dram_lane_pipe.sv
// rtl/dram_lane_pipe.sv - per-lane completion pipeline of {valid, is_read, byte} with output register
module dram_lane_pipe #(
    parameter int DATA_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_is_read,
    input  logic [DATA_W-1:0] in_byte,
    output logic              valid,
    output logic [DATA_W-1:0] data_out
);

    logic [LATENCY-1:0]             v_q;
    logic [LATENCY-1:0]             rd_q;
    logic [LATENCY-1:0][DATA_W-1:0] b_q;

    // Stage 0 loads on the sampling edge; the output register adds the final
    // edge so a request sampled at edge k completes at edge k+LATENCY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q      <= '0;
            rd_q     <= '0;
            b_q      <= '0;
            valid    <= 1'b0;
            data_out <= '0;
        end else begin
            v_q[0]  <= in_valid;
            rd_q[0] <= in_is_read;
            b_q[0]  <= in_byte;
            for (int s = 1; s < LATENCY; s++) begin
                v_q[s]  <= v_q[s-1];
                rd_q[s] <= rd_q[s-1];
                b_q[s]  <= b_q[s-1];
            end
            valid <= v_q[LATENCY-1];
            if (v_q[LATENCY-1] && rd_q[LATENCY-1]) begin
                data_out <= b_q[LATENCY-1];
            end
        end
    end

endmodule

// File: rtl/dram_model.sv
// rtl/dram_model.sv - multi-lane byte DRAM model with shared command and fixed-latency completions
module dram_model #(
    parameter int N_LANES   = dram_pkg::N_LANES,
    parameter int ADDR_W    = dram_pkg::ADDR_W,
    parameter int DATA_W    = dram_pkg::DATA_W,
    parameter int MEM_BYTES = 4096,
    parameter int LATENCY   = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [N_LANES-1:0]             en,
    input  logic [1:0]                     rdwr,
    input  logic [N_LANES-1:0][DATA_W-1:0] data_in,
    input  logic [N_LANES-1:0][ADDR_W-1:0] addr,
    output logic [N_LANES-1:0][DATA_W-1:0] data_out,
    output logic [N_LANES-1:0]             valid
);

    import dram_pkg::*;

    localparam int AW = $clog2(MEM_BYTES);

    logic [DATA_W-1:0] mem [MEM_BYTES] = '{default: '0};

    logic [N_LANES-1:0][AW-1:0]     eff;
    logic [N_LANES-1:0][DATA_W-1:0] rd_byte;
    logic [N_LANES-1:0]             req;
    logic                           is_rd;
    logic                           is_wr;
    logic                           addr_unused;

    always_comb begin
        is_rd       = (rdwr == RDWR_RD);
        is_wr       = (rdwr == RDWR_WR);
        addr_unused = ^addr;
        for (int i = 0; i < N_LANES; i++) begin
            eff[i]     = addr[i][AW-1:0];
            rd_byte[i] = mem[eff[i]];
            req[i]     = en[i] & (is_rd | is_wr);
        end
    end

    // The array is never cleared; reset only blocks new writes. Ascending lane
    // order makes the highest-numbered writer to an address win.
    always_ff @(posedge clk or negedge reset) begin
        if (reset && is_wr) begin
            for (int i = 0; i < N_LANES; i++) begin
                if (en[i]) begin
                    mem[eff[i]] <= data_in[i];
                end
            end
        end
    end

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        dram_lane_pipe #(
            .DATA_W  (DATA_W),
            .LATENCY (LATENCY)
        ) u_pipe (
            .clk        (clk),
            .rst_n      (reset),
            .in_valid   (req[i]),
            .in_is_read (is_rd),
            .in_byte    (rd_byte[i]),
            .valid      (valid[i]),
            .data_out   (data_out[i])
        );
    end

endmodule

// File: tb/tb_dram_model.sv
// tb/tb_dram_model.sv - table-driven scoreboard bench for dram_model
module tb_dram_model;

    localparam int L = 2;
    localparam logic [1:0] NOP = 2'b00, RD = 2'b01, WR = 2'b10, RSV = 2'b11;

    logic              clk = 1'b0;
    logic              reset;
    logic [15:0]       en;
    logic [1:0]        rdwr;
    logic [15:0][7:0]  data_in;
    logic [15:0][63:0] addr;
    logic [15:0][7:0]  data_out;
    logic [15:0]       valid;

    dram_model dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .rdwr     (rdwr),
        .data_in  (data_in),
        .addr     (addr),
        .data_out (data_out),
        .valid    (valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]       en;
        logic [1:0]        rdwr;
        logic [15:0][7:0]  data;
        logic [15:0][63:0] addr;
        logic [15:0]       exp_valid;
        logic [15:0][7:0]  exp_data;
    } vec_t;

    typedef struct {
        logic [15:0]      v;
        logic [15:0][7:0] d;
    } exp_t;

    vec_t             tbl[$];
    exp_t             sb[$];
    logic [15:0][7:0] exp_dout;
    int               n_tests = 0;
    int               n_fail  = 0;
    int               step_no = 0;

    task automatic cmp(string name, logic [127:0] act, logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, step_no, act, exp);
        end
    endtask

    function automatic vec_t mk(logic [15:0] e, logic [1:0] c, logic [15:0] ev);
        vec_t v;
        v.en        = e;
        v.rdwr      = c;
        v.data      = '0;
        v.addr      = '0;
        v.exp_valid = ev;
        v.exp_data  = '0;
        return v;
    endfunction

    // Each call owns one clock edge; the scoreboard entry pushed L+1 calls ago
    // describes the outputs visible at this negedge.
    task automatic drive(vec_t v);
        exp_t e;
        exp_t f;
        @(negedge clk);
        step_no++;
        for (int i = 0; i < 16; i++) begin
            if (v.exp_valid[i] && v.rdwr == RD) exp_dout[i] = v.exp_data[i];
        end
        e.v = v.exp_valid;
        e.d = exp_dout;
        sb.push_back(e);
        if (sb.size() >= L + 2) begin
            f = sb.pop_front();
            cmp("valid", valid, f.v);
            cmp("data_out", data_out, f.d);
        end
        en      = v.en;
        rdwr    = v.rdwr;
        data_in = v.data;
        addr    = v.addr;
    endtask

    task automatic do_reset(int cycles);
        exp_t z;
        @(negedge clk);
        reset = 1'b0;
        en    = '1;
        rdwr  = RD;
        #1;
        cmp("rst_valid", valid, '0);
        cmp("rst_data_out", data_out, '0);
        repeat (cycles) begin
            @(negedge clk);
            cmp("rst_valid", valid, '0);
            cmp("rst_data_out", data_out, '0);
        end
        @(negedge clk);
        reset    = 1'b1;
        en       = '0;
        rdwr     = NOP;
        exp_dout = '0;
        sb.delete();
        z.v = '0;
        z.d = '0;
        repeat (L + 1) sb.push_back(z);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vec_t rd_all;
        reset    = 1'b1;
        en       = '0;
        rdwr     = NOP;
        data_in  = '0;
        addr     = '0;
        exp_dout = '0;

        v = mk(16'h0008, WR, 16'h0008); v.data[3] = 8'hA5; v.addr[3] = 64'h10; tbl.push_back(v);
        v = mk(16'h0000, RD, 16'h0000); tbl.push_back(v); tbl.push_back(v);
        v = mk(16'h0008, RD, 16'h0008); v.addr[3] = 64'h10; v.exp_data[3] = 8'hA5; tbl.push_back(v);
        v = mk(16'h0008, WR, 16'h0008); v.data[3] = 8'h77; v.addr[3] = 64'h11; tbl.push_back(v);
        v = mk(16'h0008, RD, 16'h0008); v.addr[3] = 64'h11; v.exp_data[3] = 8'h77; tbl.push_back(v);
        v = mk(16'h0001, RD, 16'h0001); v.addr[0] = 64'h20; v.exp_data[0] = 8'h00; tbl.push_back(v);
        v = mk(16'h0204, WR, 16'h0204);
        v.data[2] = 8'h11; v.addr[2] = 64'h20; v.data[9] = 8'h99; v.addr[9] = 64'h20; tbl.push_back(v);
        v = mk(16'h0001, RD, 16'h0001); v.addr[0] = 64'h20; v.exp_data[0] = 8'h99; tbl.push_back(v);
        v = mk(16'hFFFF, WR, 16'hFFFF);
        for (int i = 0; i < 16; i++) begin
            v.data[i] = 8'(i + 1);
            v.addr[i] = 64'(4 * i);
        end
        tbl.push_back(v);
        rd_all = mk(16'hFFFF, RD, 16'hFFFF);
        for (int i = 0; i < 16; i++) begin
            rd_all.addr[i]     = 64'(4 * (15 - i));
            rd_all.exp_data[i] = 8'(16 - i);
        end
        tbl.push_back(rd_all);
        v = mk(16'h0020, WR, 16'h0020); v.data[5] = 8'h5C; v.addr[5] = 64'h1000_0000_0000_0004; tbl.push_back(v);
        v = mk(16'h0020, RD, 16'h0020); v.addr[5] = 64'h4; v.exp_data[5] = 8'h5C; tbl.push_back(v);
        v = mk(16'h0080, RD, 16'h0080); v.addr[7] = 64'hFFFF_FFFF_FFFF_F004; v.exp_data[7] = 8'h5C; tbl.push_back(v);
        v = mk(16'hFFFF, RSV, 16'h0000);
        for (int i = 0; i < 16; i++) begin
            v.data[i] = 8'hEE;
            v.addr[i] = 64'h4;
        end
        tbl.push_back(v);
        v.rdwr = NOP; tbl.push_back(v);
        v = mk(16'h0060, RD, 16'h0060);
        v.addr[5] = 64'h4; v.exp_data[5] = 8'h5C; v.addr[6] = 64'h8; v.exp_data[6] = 8'h03; tbl.push_back(v);

        do_reset(4);
        foreach (tbl[k]) drive(tbl[k]);

        // Reads in flight when reset hits must vanish; the array must survive.
        drive(rd_all);
        do_reset(3);
        rd_all.exp_data[14] = 8'h5C;
        drive(rd_all);
        for (int k = 0; k < L + 2; k++) drive(mk(16'h0000, NOP, 16'h0000));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
